// File: rtl/shared_mem_arbiter_if.sv
// Core-side memory bus shared by all request channels.
// Per-core fields are packed side by side, core i at slice i.
interface shared_mem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10
);
    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        we;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        gnt;
    logic [NUM_CORES-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter in front of a single-port shared memory,
// plus an all-cores-halted detector and a run-cycle counter.
module shared_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_mem_arbiter_if.slave  bus,
    input  logic [NUM_CORES-1:0] halted,
    output logic                 all_halted,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [NUM_CORES-1:0] gnt_c;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_we;
    logic                 wr_en;
    logic                 rd_en;
    logic [NUM_CORES-1:0] rvalid_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [DATA_W-1:0]    mem [DEPTH];

    generate
        if (NUM_CORES == 1) begin : g_single
            always_comb begin
                gnt_c = bus.req & {NUM_CORES{rst_n}};
            end
        end else begin : g_rr
            logic [PTR_W-1:0] rr_ptr;
            logic [PTR_W-1:0] gnt_k;
            logic [PTR_W-1:0] nxt_ptr;
            logic [PTR_W:0]   s;
            logic             found;

            // Scan from rr_ptr upward with wrap; first requester wins.
            always_comb begin
                gnt_c = '0;
                gnt_k = '0;
                found = 1'b0;
                s     = '0;
                for (int j = 0; j < NUM_CORES; j++) begin
                    s = {1'b0, rr_ptr} + (PTR_W+1)'(j);
                    if (s >= (PTR_W+1)'(NUM_CORES))
                        s = s - (PTR_W+1)'(NUM_CORES);
                    if (!found && rst_n && bus.req[s[PTR_W-1:0]]) begin
                        found = 1'b1;
                        gnt_c[s[PTR_W-1:0]] = 1'b1;
                        gnt_k = s[PTR_W-1:0];
                    end
                end
            end

            always_comb begin
                if (gnt_k == PTR_W'(NUM_CORES - 1))
                    nxt_ptr = '0;
                else
                    nxt_ptr = gnt_k + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rr_ptr <= '0;
                else if (|gnt_c)
                    rr_ptr <= nxt_ptr;
            end
        end
    endgenerate

    assign bus.gnt    = gnt_c;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt_c[i]) begin
                sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
                sel_we    = bus.we[i];
            end
        end
    end

    assign wr_en = (|gnt_c) & sel_we;
    assign rd_en = (|gnt_c) & ~sel_we;

    // Storage is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[sel_addr] <= sel_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt_c & ~bus.we;
            if (rd_en)
                rdata_q <= mem[sel_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_halted  <= 1'b0;
            cycle_count <= '0;
        end else begin
            all_halted <= &halted;
            if (!all_halted && (cycle_count != {CNT_W{1'b1}}))
                cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: grants, memory path,
// reset behaviour, halt detection and counter saturation.
module tb_shared_mem_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 10;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   halted  = '0;
    logic [N-1:0]   halted2 = '0;
    logic           all_halted;
    logic           all_halted2;
    logic [31:0]    cycle_count;
    logic [3:0]     cycle_count2;
    int             n_assert = 0;
    int             n_fail   = 0;

    always #5 clk = ~clk;

    shared_mem_arbiter_if #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
    shared_mem_arbiter_if #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) bus2 ();

    shared_mem_arbiter #(
        .NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .halted(halted),
        .all_halted(all_halted), .cycle_count(cycle_count)
    );

    shared_mem_arbiter #(
        .NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(4)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .halted(halted2),
        .all_halted(all_halted2), .cycle_count(cycle_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[c]          = 1'b1;
        bus.we[c]           = w;
        bus.addr[c*AW +: AW] = a;
        bus.wdata[c*DW +: DW] = d;
    endtask

    task automatic idle();
        bus.req = '0;
        bus.we  = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        bus.req = '1;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        chk("rst_all_halted", 32'(all_halted), 32'h0);
        chk("rst_count", cycle_count, 32'h0);
        chk("rst_count_small", 32'(cycle_count2), 32'h0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = '0; bus.we  = '0; bus.addr  = '0; bus.wdata  = '0;
        bus2.req = '0; bus2.we = '0; bus2.addr = '0; bus2.wdata = '0;

        // Write then read-back on core 0
        do_reset();
        drive(0, 1'b1, 10'd5, 16'h1234);
        #1;
        chk("wr_gnt", 32'(bus.gnt), 32'h1);
        tick();
        chk("wr_no_rvalid", 32'(bus.rvalid), 32'h0);
        drive(0, 1'b0, 10'd5, 16'h0);
        #1;
        chk("rd_gnt", 32'(bus.gnt), 32'h1);
        tick();
        chk("rd_rvalid", 32'(bus.rvalid), 32'h1);
        chk("rd_rdata", 32'(bus.rdata), 32'h1234);
        idle();
        tick();
        chk("rvalid_pulse", 32'(bus.rvalid), 32'h0);
        chk("rdata_hold", 32'(bus.rdata), 32'h1234);
        chk("count_run", cycle_count, 32'd3);

        // Reset lands on a read grant cycle
        drive(0, 1'b0, 10'd5, 16'h0);
        #1;
        chk("pre_rst_gnt", 32'(bus.gnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        idle();
        tick();
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("mid_rst_rdata", 32'(bus.rdata), 32'h0);
        chk("mid_rst_count", cycle_count, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rvalid", 32'(bus.rvalid), 32'h0);
        drive(0, 1'b0, 10'd5, 16'h0);
        #1;
        chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
        tick();
        chk("retained_rvalid", 32'(bus.rvalid), 32'h1);
        chk("retained_rdata", 32'(bus.rdata), 32'h1234);
        idle();

        // All cores requesting: writes, then reads, one per cycle
        do_reset();
        for (int i = 0; i < N; i++)
            drive(i, 1'b1, AW'(10 + i), DW'(16'hA000 + i));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_wr_gnt", 32'(bus.gnt), 32'd1 << (k % 4));
            tick();
        end
        bus.we = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_rd_gnt", 32'(bus.gnt), 32'd1 << k);
            tick();
            chk("rr_rd_rvalid", 32'(bus.rvalid), 32'd1 << k);
            chk("rr_rd_rdata", 32'(bus.rdata), 32'hA000 + k);
        end
        idle();

        // Pointer at 2 with cores 0 and 3 requesting
        drive(1, 1'b0, 10'd11, 16'h0);
        #1;
        chk("ptr_setup_gnt", 32'(bus.gnt), 32'h2);
        tick();
        idle();
        drive(0, 1'b0, 10'd5, 16'h0);
        drive(3, 1'b0, 10'd13, 16'h0);
        #1;
        chk("wrap_gnt_3", 32'(bus.gnt), 32'h8);
        tick();
        chk("wrap_rvalid_3", 32'(bus.rvalid), 32'h8);
        chk("wrap_rdata_3", 32'(bus.rdata), 32'hA003);
        chk("wrap_gnt_0", 32'(bus.gnt), 32'h1);
        tick();
        chk("wrap_rvalid_0", 32'(bus.rvalid), 32'h1);
        chk("wrap_rdata_0", 32'(bus.rdata), 32'h1234);
        idle();

        // Halt detection and counter freeze/resume
        do_reset();
        repeat (7) tick();
        chk("halt_count7", cycle_count, 32'd7);
        chk("small_count7", 32'(cycle_count2), 32'd7);
        halted = 4'b0001;
        tick();
        halted = 4'b0011;
        tick();
        halted = 4'b0111;
        tick();
        chk("halt_count10", cycle_count, 32'd10);
        halted = 4'b1111;
        #1;
        chk("halt_not_yet", 32'(all_halted), 32'h0);
        tick();
        chk("halt_set", 32'(all_halted), 32'h1);
        chk("halt_count11", cycle_count, 32'd11);
        repeat (3) tick();
        chk("halt_frozen", cycle_count, 32'd11);
        halted = 4'b1101;
        tick();
        chk("halt_clear", 32'(all_halted), 32'h0);
        chk("halt_resume0", cycle_count, 32'd11);
        tick();
        chk("halt_resume1", cycle_count, 32'd12);
        halted = '0;

        // Narrow counter saturates
        do_reset();
        repeat (14) tick();
        chk("small_count14", 32'(cycle_count2), 32'hE);
        tick();
        chk("small_count15", 32'(cycle_count2), 32'hF);
        repeat (3) tick();
        chk("small_sat", 32'(cycle_count2), 32'hF);
        chk("wide_count18", cycle_count, 32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4: number of core request channels, range 1..16.
REQ-002 Parameter DATA_W, default 16: memory word width in bits.
REQ-003 Parameter ADDR_W, default 10: word address width; memory depth SHALL be 2**ADDR_W words.
REQ-004 Parameter CNT_W, default 32: cycle counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req  input  NUM_CORES  per-core access request, bit i = core i.
REQ-008 we  input  NUM_CORES  per-core write enable, qualified by req[i].
REQ-009 addr  input  NUM_CORES*ADDR_W  per-core word address, slice i at [i*ADDR_W +: ADDR_W].
REQ-010 wdata  input  NUM_CORES*DATA_W  per-core write data, sliced as addr.
REQ-011 halted  input  NUM_CORES  per-core halt status.
REQ-012 gnt  output  NUM_CORES  one-hot grant, combinational, same cycle as accepted request.
REQ-013 rvalid  output  NUM_CORES  one-hot read-data-valid, registered.
REQ-014 rdata  output  DATA_W  read data, shared by all cores, valid when any rvalid bit set.
REQ-015 all_halted  output  1  registered, high when every halted bit was high at the previous edge.
REQ-016 cycle_count  output  CNT_W  cycles elapsed since reset release while not all_halted.

Function
REQ-017 At most one gnt bit SHALL be high per cycle; gnt[i] only when req[i] is high.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, ascending with wrap from NUM_CORES-1 to 0; first requesting core wins.
REQ-019 On any grant to core k, rr_ptr SHALL update to (k+1) mod NUM_CORES at the edge; with no grant rr_ptr holds.
REQ-020 Granted write (we[k]=1) SHALL store wdata slice k at addr slice k at the granting edge; no rvalid results.
REQ-021 Granted read SHALL set rvalid[k] and drive rdata = mem[addr k] exactly one cycle after the grant cycle; rvalid is a one-cycle pulse.
REQ-022 Read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-023 A core with req high and no gnt SHALL hold req, we, addr, wdata stable; arbiter imposes no timeout.
REQ-024 Back-to-back grants to different cores SHALL sustain one access per cycle; a single requesting core SHALL be granted every cycle.
REQ-025 rdata SHALL hold its last value when no rvalid bit is set.
REQ-026 cycle_count SHALL increment by 1 each edge while all_halted is low, saturate at all ones, and freeze while all_halted is high.
REQ-027 all_halted SHALL re-clear if any halted bit drops; cycle_count then resumes from its frozen value.
REQ-028 Memory contents SHALL be uninitialised by hardware; no behaviour depends on them before first write.
REQ-029 NUM_CORES=1 SHALL degenerate to gnt = req with rr_ptr constant 0.

Reset
REQ-030 While rst_n low: rr_ptr=0, rvalid=0, rdata=0, all_halted=0, cycle_count=0; gnt forced 0; no memory write occurs.
REQ-031 rst_n assertion mid-access SHALL discard the pending read (no rvalid after release); memory contents are not cleared.
REQ-032 First grant after reset release SHALL use rr_ptr=0.

Verification
REQ-033 Core 0 writes 0x1234 to addr 5, next cycle reads addr 5 -> gnt[0] both cycles, rvalid[0] pulse one cycle after read grant, rdata=0x1234.
REQ-034 NUM_CORES=4, all req held high continuously after reset -> gnt sequence 0,1,2,3,0,... one per cycle, no gaps.
REQ-035 rr_ptr=2, req=4'b1001 -> gnt=4'b1000; next cycle same req -> gnt=4'b0001.
REQ-036 halted bits set one per cycle ending at cycle 10 -> all_halted high from following edge, cycle_count frozen at 11; drop halted[1] -> counting resumes.
REQ-037 rst_n pulsed low the cycle after a read grant -> no rvalid, all outputs at reset values, previously written data still readable.
REQ-038 CNT_W=4, no halts -> cycle_count reaches 4'hF and holds.
